// File: rtl/sar_search.sv
// sar_search: unsigned binary search driver for an external comparator.
// The comparator's great/equal/less flags answer the probe presented in the same cycle.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             great,
    input  logic             equal,
    input  logic             less,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       steps
);
    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    localparam logic [3:0]       MAX_STEPS = 4'(WIDTH + 1);
    localparam logic [WIDTH-1:0] MID0      = {1'b0, {(WIDTH-1){1'b1}}};

    state_t           r_state;
    logic [WIDTH-1:0] r_low, r_high, r_probe, r_result;
    logic [3:0]       r_steps;
    logic             r_busy, r_done, r_found, r_err;

    logic             w_gt, w_eq, w_lt, w_abort;
    logic [WIDTH-1:0] w_lo_n, w_hi_n, w_mid;
    logic [WIDTH:0]   w_sum;
    logic [3:0]       w_stp;

    assign w_gt   = great & ~equal & ~less;
    assign w_eq   = equal & ~great & ~less;
    assign w_lt   = less & ~great & ~equal;
    assign w_lo_n = w_lt ? r_probe + 1'b1 : r_low;
    assign w_hi_n = w_gt ? r_probe - 1'b1 : r_high;
    // Midpoint needs the carry bit, so the sum is one bit wider than the range.
    assign w_sum  = {1'b0, w_lo_n} + {1'b0, w_hi_n};
    assign w_mid  = w_sum[WIDTH:1];
    assign w_stp  = r_steps + 4'd1;
    assign w_abort = ~(w_gt | w_eq | w_lt) | (w_gt & (r_probe == r_low))
                   | (w_lt & (r_probe == r_high)) | (w_stp >= MAX_STEPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_low    <= '0;
            r_high   <= '1;
            r_probe  <= '0;
            r_result <= '0;
            r_steps  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_low   <= '0;
                        r_high  <= '1;
                        r_probe <= MID0;
                        r_steps <= '0;
                        r_found <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= PROBE;
                    end
                end
                PROBE: begin
                    r_steps <= w_stp;
                    if (w_eq) begin
                        r_result <= r_probe;
                        r_found  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else if (w_abort) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_low   <= w_lo_n;
                        r_high  <= w_hi_n;
                        r_probe <= w_mid;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign probe  = r_probe;
    assign busy   = r_busy;
    assign done   = r_done;
    assign found  = r_found;
    assign err    = r_err;
    assign result = r_result;
    assign steps  = r_steps;
endmodule
